// File: rtl/ctrl_poller.sv
// ctrl_poller: polls four shift-register game pads over a shared latch/clock bus
// and publishes a coherent snapshot of presence and button state once per poll.
module ctrl_poller #(
  parameter int CLK_DIV     = 8,
  parameter int POLL_PERIOD = 250000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable_i,
  input  logic [3:0]   pad_data_i,
  output logic         pad_latch_o,
  output logic         pad_clk_o,
  output logic [3:0]   ctrl_present,
  output logic [127:0] ctrl_data,
  output logic         frame_o
);

  localparam int TW = $clog2(POLL_PERIOD);
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_PERIOD - 1);
  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, LATCH, CLK_HI, CLK_LO, UPDATE} state_t;

  state_t          state, state_next;
  logic [3:0]      sync1, sync2;
  logic [TW-1:0]   timer;
  logic [PW-1:0]   phase;
  logic [5:0]      bit_cnt;
  logic            armed;
  logic            phase_done;
  logic            start_poll;
  logic [3:0]      presence_shadow;
  logic [3:0][31:0] data_shadow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pad_data_i;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // 'armed' lets a poll start at once after reset or after enable returns,
  // instead of waiting out a full period from a held-at-zero timer.
  always_comb begin
    state_next = state;
    start_poll = 1'b0;
    phase_done = (state == LATCH) ? (phase == LATCH_LAST) : (phase == HALF_LAST);
    case (state)
      IDLE: begin
        if (enable_i && (armed || timer == TIMER_LAST)) begin
          start_poll = 1'b1;
          state_next = LATCH;
        end
      end
      LATCH:   if (phase_done) state_next = CLK_HI;
      CLK_HI:  if (phase_done) state_next = CLK_LO;
      CLK_LO:  if (phase_done) state_next = (bit_cnt == 6'd31) ? UPDATE : CLK_HI;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer   <= '0;
      armed   <= 1'b1;
      phase   <= '0;
      bit_cnt <= '0;
    end else begin
      if (start_poll || (state == IDLE && !enable_i)) timer <= '0;
      else                                            timer <= timer + 1'b1;

      if (start_poll)                         armed <= 1'b0;
      else if (state == IDLE && !enable_i)    armed <= 1'b1;

      if (state_next != state || state == IDLE) phase <= '0;
      else                                      phase <= phase + 1'b1;

      if (state == LATCH)                      bit_cnt <= '0;
      else if (state == CLK_LO && phase_done)  bit_cnt <= bit_cnt + 6'd1;
    end
  end

  // Pads drive active-low buttons, so stored bits are inverted to 1 = pressed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presence_shadow <= '0;
      data_shadow     <= '0;
    end else begin
      if (state == LATCH && phase_done) presence_shadow <= sync2;
      if (state == CLK_HI && phase_done) begin
        for (int i = 0; i < 4; i++) data_shadow[i][bit_cnt[4:0]] <= ~sync2[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pad_latch_o  <= 1'b0;
      pad_clk_o    <= 1'b1;
      frame_o      <= 1'b0;
      ctrl_present <= '0;
      ctrl_data    <= '0;
    end else begin
      pad_latch_o <= (state_next == LATCH);
      pad_clk_o   <= (state_next != CLK_LO);
      frame_o     <= (state_next == UPDATE);
      if (state_next == UPDATE) begin
        ctrl_present <= presence_shadow;
        for (int i = 0; i < 4; i++)
          ctrl_data[32*i +: 32] <= presence_shadow[i] ? data_shadow[i] : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_poller.sv
// tb_ctrl_poller: self-checking bench with behavioural pad models, a snapshot
// reference model, a vector table and hand-written multi-cycle sequences.
module tb_ctrl_poller;

  localparam int CLK_DIV     = 4;
  localparam int POLL_PERIOD = 400;

  typedef struct {
    logic [3:0]   present;
    logic [127:0] data;
  } frame_t;

  typedef struct {
    logic [3:0]   conn;
    logic [127:0] words;
    logic [3:0]   exp_present;
    logic [127:0] exp_data;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable_i;
  logic [3:0]   pad_data_i;
  logic         pad_latch_o;
  logic         pad_clk_o;
  logic [3:0]   ctrl_present;
  logic [127:0] ctrl_data;
  logic         frame_o;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  logic [3:0]   pad_conn  = 4'h0;
  logic [127:0] pad_words = '0;
  logic [127:0] pad_shift = '0;
  int           pad_idx   = 0;
  logic         prev_latch = 1'b0;
  logic         prev_clk   = 1'b1;
  frame_t       exp_q[$];
  frame_t       mon_exp;
  vec_t         tbl[6];

  ctrl_poller #(.CLK_DIV(CLK_DIV), .POLL_PERIOD(POLL_PERIOD)) dut (
    .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .pad_data_i(pad_data_i),
    .pad_latch_o(pad_latch_o), .pad_clk_o(pad_clk_o), .ctrl_present(ctrl_present),
    .ctrl_data(ctrl_data), .frame_o(frame_o)
  );

  always #16 clk = ~clk;
  always @(posedge clk) cycle++;

  function automatic frame_t modelFrame(input logic [3:0] conn, input logic [127:0] words);
    frame_t f;
    f.present = conn;
    f.data    = '0;
    for (int i = 0; i < 4; i++) if (conn[i]) f.data[32*i +: 32] = words[32*i +: 32];
    return f;
  endfunction

  // Pad shift registers: buttons are captured when the latch falls, the first
  // bit is presented immediately and each pad-clock rise advances one bit.
  always @(pad_latch_o or pad_clk_o) begin
    if (pad_latch_o) pad_idx = 0;
    else if (prev_latch) begin
      pad_shift = pad_words;
      pad_idx   = 0;
      if (reset_n) exp_q.push_back(modelFrame(pad_conn, pad_words));
    end else if (pad_clk_o && !prev_clk) pad_idx++;
    prev_latch = pad_latch_o;
    prev_clk   = pad_clk_o;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (!pad_conn[i])                     pad_data_i[i] = 1'b0;
      else if (pad_latch_o || pad_idx > 31) pad_data_i[i] = 1'b1;
      else                                  pad_data_i[i] = ~pad_shift[32*i + pad_idx];
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] conn, input logic [127:0] words);
    pad_conn  = conn;
    pad_words = words;
  endtask

  // which: 0 = frame_o high, 1 = pad_latch_o high, 2 = pad_latch_o low
  task automatic waitFor(input int which, input int budget, input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if ((which == 0 && frame_o) || (which == 1 && pad_latch_o) || (which == 2 && !pad_latch_o)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: no event within %0d cycles", name, budget);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && frame_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL modelFrame: frame_o with no poll expected, got 1, want 0");
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("modelPresent", ctrl_present, mon_exp.present);
        checkOutput("modelData", ctrl_data, mon_exp.data);
      end
    end
  end

  initial begin
    #(32 * 40000);
    $display("[TB] FAIL watchdog: time limit reached, got running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    bit seen;
    int latch_cnt, clk_falls, wave_err, stable_err, last_frame;
    logic [264:0] rec_latch, rec_clk, rec_frame;
    logic [127:0] snap;
    logic exp_l, exp_c;

    tbl[0] = '{4'b1101, 128'h00112233_44556677_FFFFFFFF_CCDDEEFF, 4'b1101, 128'h00112233_44556677_00000000_CCDDEEFF};
    tbl[1] = '{4'hF, 128'h0, 4'hF, 128'h0};
    tbl[2] = '{4'hF, {128{1'b1}}, 4'hF, {128{1'b1}}};
    tbl[3] = '{4'h0, 128'h12345678_9ABCDEF0_0F0F0F0F_A5A5A5A5, 4'h0, 128'h0};
    tbl[4] = '{4'h8, 128'h80000001_DEADBEEF_CAFEF00D_13572468, 4'h8, 128'h80000001_00000000_00000000_00000000};
    tbl[5] = '{4'h6, 128'h11111111_00000001_80000000_22222222, 4'h6, 128'h00000000_00000001_80000000_00000000};

    reset_n  = 1'b0;
    enable_i = 1'b0;
    applyStimulus(4'h0, 128'h0);
    repeat (3) @(negedge clk);
    checkOutput("resetLatch", pad_latch_o, 1'b0);
    checkOutput("resetPadClk", pad_clk_o, 1'b1);
    checkOutput("resetFrame", frame_o, 1'b0);
    checkOutput("resetPresent", ctrl_present, 4'h0);
    checkOutput("resetData", ctrl_data, 128'h0);

    // First poll starts right after release; record its full waveform.
    applyStimulus(tbl[0].conn, tbl[0].words);
    enable_i = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 265; c++) begin
      @(negedge clk);
      rec_latch[c] = pad_latch_o;
      rec_clk[c]   = pad_clk_o;
      rec_frame[c] = frame_o;
    end
    latch_cnt = 0; clk_falls = 0; wave_err = 0;
    for (int c = 0; c < 265; c++) begin
      exp_l = (c < 8);
      exp_c = !(c >= 8 && c < 264 && ((c - 8) % 8) >= 4);
      if (rec_latch[c]) latch_cnt++;
      if (c > 0 && rec_clk[c-1] && !rec_clk[c]) clk_falls++;
      if (rec_latch[c] !== exp_l || rec_clk[c] !== exp_c || rec_frame[c] !== (c == 264)) wave_err++;
    end
    checkOutput("latchHighCycles", latch_cnt, 8);
    checkOutput("padClkFalls", clk_falls, 32);
    checkOutput("waveShape", wave_err, 0);
    checkOutput("frameAtPollEnd", rec_frame[264], 1'b1);
    checkOutput("vecPresent0", ctrl_present, tbl[0].exp_present);
    checkOutput("vecData0", ctrl_data, tbl[0].exp_data);
    last_frame = cycle;

    for (int i = 1; i < 6; i++) begin
      applyStimulus(tbl[i].conn, tbl[i].words);
      waitFor(0, 450, "vecFrame", ok);
      if (ok) begin
        checkOutput($sformatf("framePeriod%0d", i), cycle - last_frame, POLL_PERIOD);
        last_frame = cycle;
        checkOutput($sformatf("vecPresent%0d", i), ctrl_present, tbl[i].exp_present);
        checkOutput($sformatf("vecData%0d", i), ctrl_data, tbl[i].exp_data);
      end
    end

    // Hot unplug of pad 3 between polls.
    applyStimulus(4'hF, 128'hF00DF00D_ABCD1234_01020304_0A0B0C0D);
    waitFor(0, 450, "plugFrame", ok);
    checkOutput("plugPresent3", ctrl_present[3], 1'b1);
    checkOutput("plugData3", ctrl_data[127:96], 32'hF00DF00D);
    applyStimulus(4'h7, 128'hF00DF00D_ABCD1234_01020304_0A0B0C0D);
    waitFor(0, 450, "unplugFrame", ok);
    checkOutput("unplugPresent3", ctrl_present[3], 1'b0);
    checkOutput("unplugData3", ctrl_data[127:96], 32'h0);
    checkOutput("unplugData2", ctrl_data[95:64], 32'hABCD1234);

    // Pad 2 pattern changes mid-poll; outputs must stay frozen until UPDATE.
    snap = ctrl_data;
    waitFor(1, 450, "cohLatch", ok);
    repeat (50) @(negedge clk);
    pad_words[95:64] = 32'h55AA33CC;
    stable_err = 0;
    seen = 1'b0;
    for (int n = 0; n < 450; n++) begin
      @(negedge clk);
      if (frame_o) begin
        seen = 1'b1;
        break;
      end
      if (ctrl_data !== snap) stable_err++;
    end
    checkOutput("cohFrameSeen", seen, 1'b1);
    checkOutput("cohStable", stable_err, 0);
    checkOutput("cohOldValue", ctrl_data[95:64], 32'hABCD1234);
    waitFor(0, 450, "cohNextFrame", ok);
    checkOutput("cohNewValue", ctrl_data[95:64], 32'h55AA33CC);

    // Randomized polls, including button changes after the latch.
    for (int r = 0; r < 10; r++) begin
      applyStimulus(4'($urandom), {$urandom, $urandom, $urandom, $urandom});
      waitFor(1, 450, "rndLatch", ok);
      repeat ($urandom_range(10, 200)) @(negedge clk);
      pad_words = {$urandom, $urandom, $urandom, $urandom};
      waitFor(0, 450, "rndFrame", ok);
      @(negedge clk);
      checkOutput("frameOneCycle", frame_o, 1'b0);
    end

    // Enable gating: an in-flight poll completes, then polling stops.
    applyStimulus(tbl[0].conn, tbl[0].words);
    waitFor(1, 450, "egLatch", ok);
    repeat (20) @(negedge clk);
    enable_i = 1'b0;
    waitFor(0, 400, "egFrame", ok);
    checkOutput("egFrameSeen", ok, 1'b1);
    latch_cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (pad_latch_o) latch_cnt++;
    end
    checkOutput("egNoLatch", latch_cnt, 0);
    enable_i = 1'b1;
    @(negedge clk);
    checkOutput("egRestart", pad_latch_o, 1'b1);

    // Asynchronous reset during CLK_LO of bit 10.
    waitFor(2, 50, "mrLatchFall", ok);
    repeat (84) @(negedge clk);
    checkOutput("mrInClkLo", pad_clk_o, 1'b0);
    checkOutput("mrPresentBefore", ctrl_present, tbl[0].exp_present);
    #4 reset_n = 1'b0;
    #1;
    checkOutput("mrPresent", ctrl_present, 4'h0);
    checkOutput("mrData", ctrl_data, 128'h0);
    checkOutput("mrPadClk", pad_clk_o, 1'b1);
    checkOutput("mrLatch", pad_latch_o, 1'b0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    waitFor(0, 300, "mrFrame", ok);
    checkOutput("mrFreshPresent", ctrl_present, tbl[0].exp_present);
    checkOutput("mrFreshData", ctrl_data, tbl[0].exp_data);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
